// File: rtl/sodor5_instr_stream_gen.sv
// Seedable random instruction-stream generator for the sodor5 verif harness.
// Emits a NOP prelude, NUM_INSTR random R/I/load words, a NOP drain, then parks in DONE.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start, instr_valid low
//   S_PRELUDE| presenting PRE_NOPS valid NOPs
//   S_RUN    | presenting random words, LFSR advances once per fire
//   S_DRAIN  | presenting DRAIN_NOPS valid NOPs
//   S_DONE   | stream finished, held until reset
module sodor5_instr_stream_gen #(
    parameter logic [31:0] SEED       = 32'h000001F5,
    parameter int unsigned NUM_INSTR  = 100,
    parameter int unsigned PRE_NOPS   = 3,
    parameter int unsigned DRAIN_NOPS = 5,
    parameter logic [4:0]  REG_MASK   = 5'h1F,
    parameter int unsigned DMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        haz_en,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] issued,
    output logic        done
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [11:0] LD_MASK   = 12'(4 * DMEM_WORDS - 1);
    localparam logic [15:0] NUM_LAST  = 16'(NUM_INSTR);
    localparam logic [15:0] PRE_CNT   = 16'(PRE_NOPS);
    localparam logic [15:0] DRAIN_CNT = 16'(DRAIN_NOPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELUDE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d, lfsr_step;
    logic [4:0]  prev_rd_q, prev_rd_d;
    logic [15:0] nop_cnt_q, nop_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] issued_q, issued_d;
    logic        fire;

    // Kind encoding: 0 R-type, 1 I-type ALU, 2 byte load.
    function automatic logic [31:0] gen_word(input logic [31:0] l, input logic [1:0] md,
                                             input logic [4:0] prd, input logic hz);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [1:0]  kind;
        logic        alt;
        logic [31:0] w;
        rd   = l[11:7] & REG_MASK;
        rs1  = l[19:15] & REG_MASK;
        rs2  = l[24:20] & REG_MASK;
        f3   = l[14:12];
        imm  = l[31:20];
        kind = md;
        if (md == 2'd3) begin
            case (l[6:5])
                2'd2:    kind = 2'd1;
                2'd3:    kind = 2'd2;
                default: kind = 2'd0;
            endcase
        end
        if (hz && (l[1:0] == 2'b00) && (prd != 5'd0) && (kind != 2'd2)) rs1 = prd;
        alt = l[30] & ((f3 == 3'd0) | (f3 == 3'd5));
        case (kind)
            2'd0: w = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            2'd1: begin
                if (f3 == 3'd1) imm = imm & 12'h01F;
                if (f3 == 3'd5) imm = imm & 12'h41F;
                w = {imm, rs1, f3, rd, 7'b0010011};
            end
            default: w = {l[31:20] & LD_MASK, 5'd0, (l[14] ? 3'b100 : 3'b000), rd, 7'b0000011};
        endcase
        return w;
    endfunction

    assign fire      = valid_q & instr_ready;
    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        prev_rd_d = prev_rd_q;
        nop_cnt_d = nop_cnt_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        issued_d  = issued_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    valid_d = 1'b1;
                    if (PRE_NOPS == 0) begin
                        state_d = S_RUN;
                        instr_d = gen_word(lfsr_q, mode, prev_rd_q, haz_en);
                    end else begin
                        state_d   = S_PRELUDE;
                        nop_cnt_d = PRE_CNT;
                        instr_d   = NOP;
                    end
                end
            end
            S_PRELUDE: begin
                if (fire) begin
                    if (nop_cnt_q == 16'd1) begin
                        state_d = S_RUN;
                        instr_d = gen_word(lfsr_q, mode, prev_rd_q, haz_en);
                    end else begin
                        nop_cnt_d = nop_cnt_q - 16'd1;
                    end
                end
            end
            S_RUN: begin
                if (fire) begin
                    lfsr_d    = lfsr_step;
                    prev_rd_d = instr_q[11:7];
                    if (issued_q != NUM_LAST) issued_d = issued_q + 16'd1;
                    // The word being accepted is the predecessor of the one built here.
                    if (issued_q + 16'd1 == NUM_LAST) begin
                        instr_d = NOP;
                        if (DRAIN_NOPS == 0) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                        end else begin
                            state_d   = S_DRAIN;
                            nop_cnt_d = DRAIN_CNT;
                        end
                    end else begin
                        instr_d = gen_word(lfsr_step, mode, instr_q[11:7], haz_en);
                    end
                end
            end
            S_DRAIN: begin
                if (fire) begin
                    if (nop_cnt_q == 16'd1) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        instr_d = NOP;
                    end else begin
                        nop_cnt_d = nop_cnt_q - 16'd1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                instr_d = NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            prev_rd_q <= 5'd0;
            nop_cnt_q <= 16'd0;
            instr_q   <= NOP;
            valid_q   <= 1'b0;
            issued_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            prev_rd_q <= prev_rd_d;
            nop_cnt_q <= nop_cnt_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            issued_q  <= issued_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign issued      = issued_q;
    assign done        = (state_q == S_DONE);

endmodule
